// File: rtl/pid_chan_sched_pkg.sv
// pid_chan_sched_pkg: shared defaults and the config endpoint map for the
// PID channel scheduler. Optional feature macro: PID_SCHED_OVR_CNT_EN.
package pid_chan_sched_pkg;

    localparam int N_CHAN_DEF         = 8;
    localparam int W_CHAN_DEF         = 5;
    localparam int W_DIN_DEF          = 18;
    localparam int W_WR_ADDR_DEF      = 16;
    localparam int W_WR_CHAN_DEF      = 16;
    localparam int W_WR_DATA_DEF      = 48;
    localparam int LOCKOUT_CYCLES_DEF = 6;
    localparam int W_OVR_DEF          = 16;

    // Config endpoint map shared with the rest of the register space.
    localparam logic [15:0] pid_sched_en_addr      = 16'h0040;
    localparam logic [15:0] pid_sched_ovr_clr_addr = 16'h0041;

    // Width of a down-counter that must hold LOCKOUT_CYCLES-1.
    function automatic int lock_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/pid_chan_sched_if.sv
// pid_chan_sched_if: ADC sample bus, config write bus and PID issue bus of
// the scheduler. The overrun count is present only with PID_SCHED_OVR_CNT_EN.
interface pid_chan_sched_if
    import pid_chan_sched_pkg::*;
#(
    parameter int N_CHAN    = N_CHAN_DEF,
    parameter int W_CHAN    = W_CHAN_DEF,
    parameter int W_DIN     = W_DIN_DEF,
    parameter int W_WR_ADDR = W_WR_ADDR_DEF,
    parameter int W_WR_CHAN = W_WR_CHAN_DEF,
    parameter int W_WR_DATA = W_WR_DATA_DEF,
    parameter int W_OVR     = W_OVR_DEF
);

    // ADC front end
    logic                     adc_dv_in;
    logic [W_CHAN-1:0]        adc_chan_in;
    logic signed [W_DIN-1:0]  adc_data_in;

    // Config write port
    logic                     wr_en;
    logic [W_WR_ADDR-1:0]     wr_addr;
    logic [W_WR_CHAN-1:0]     wr_chan;
    logic [W_WR_DATA-1:0]     wr_data;

    // Issue to the PID filter
    logic                     dv_out;
    logic [W_CHAN-1:0]        chan_out;
    logic signed [W_DIN-1:0]  data_out;
    logic [N_CHAN-1:0]        pending_out;
`ifdef PID_SCHED_OVR_CNT_EN
    logic [W_OVR-1:0]         ovr_count_out;
`endif

    // Source side: drives samples and config, observes issues.
    modport master (
        output adc_dv_in, adc_chan_in, adc_data_in,
        output wr_en, wr_addr, wr_chan, wr_data,
        input  dv_out, chan_out, data_out, pending_out
`ifdef PID_SCHED_OVR_CNT_EN
        , ovr_count_out
`endif
    );

    // Scheduler side.
    modport slave (
        input  adc_dv_in, adc_chan_in, adc_data_in,
        input  wr_en, wr_addr, wr_chan, wr_data,
        output dv_out, chan_out, data_out, pending_out
`ifdef PID_SCHED_OVR_CNT_EN
        , ovr_count_out
`endif
    );

endinterface

// File: rtl/pid_chan_sched_rr_arbiter.sv
// rr_arbiter: purely combinational round-robin pick. The search starts at
// the channel after last_gnt and wraps modulo N_CHAN.
module rr_arbiter
    import pid_chan_sched_pkg::*;
#(
    parameter int N_CHAN = N_CHAN_DEF,
    parameter int W_CHAN = W_CHAN_DEF
) (
    input  logic [N_CHAN-1:0] req,
    input  logic [W_CHAN-1:0] last_gnt,
    output logic              gnt_vld,
    output logic [W_CHAN-1:0] gnt_idx
);

    logic [W_CHAN-1:0] cand;

    // Walk candidates in rotation order; the first requesting one wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise paths that skip an assignment infer a latch.
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = last_gnt;
        for (int k = 0; k < N_CHAN; k++) begin
            cand = (cand == W_CHAN'(N_CHAN - 1)) ? '0 : cand + W_CHAN'(1);
            for (int c = 0; c < N_CHAN; c++) begin
                if (!gnt_vld && req[c] && (cand == W_CHAN'(c))) begin
                    gnt_vld = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
    end

endmodule

// File: rtl/pid_chan_sched.sv
// pid_chan_sched: round-robin scheduler between the ADC front end and the
// multi-channel PID filter. Keeps the newest sample per channel, issues at
// most one per cycle and locks a channel out for LOCKOUT_CYCLES edges after
// each grant. Optional feature macro: PID_SCHED_OVR_CNT_EN (overrun counter).
module pid_chan_sched
    import pid_chan_sched_pkg::*;
#(
    parameter int N_CHAN         = N_CHAN_DEF,
    parameter int W_CHAN         = W_CHAN_DEF,
    parameter int W_DIN          = W_DIN_DEF,
    parameter int W_WR_ADDR      = W_WR_ADDR_DEF,
    parameter int W_WR_CHAN      = W_WR_CHAN_DEF,
    parameter int W_WR_DATA      = W_WR_DATA_DEF,
    parameter int LOCKOUT_CYCLES = LOCKOUT_CYCLES_DEF,
    parameter int W_OVR          = W_OVR_DEF
) (
    input  logic              clk_in,
    input  logic              rst_in,
    pid_chan_sched_if.slave   bus
);

    localparam int                W_LOCK    = lock_width(LOCKOUT_CYCLES);
    localparam logic [W_LOCK-1:0] LOCK_LOAD = W_LOCK'(LOCKOUT_CYCLES - 1);

    // Per-channel state
    logic signed [W_DIN-1:0] hold     [N_CHAN];
    logic [W_LOCK-1:0]       lock_cnt [N_CHAN];
    logic [N_CHAN-1:0]       pending;
    logic [N_CHAN-1:0]       en_mask;
    logic [W_CHAN-1:0]       rr_ptr;

    // Issue registers
    logic                    dv_q;
    logic [W_CHAN-1:0]       chan_q;
    logic signed [W_DIN-1:0] data_q;

    // Per-edge decode
    logic                    en_wr;
    logic [N_CHAN-1:0]       en_new;
    logic [N_CHAN-1:0]       cap_vec;
    logic [N_CHAN-1:0]       eligible;
    logic [N_CHAN-1:0]       gnt_vec;
    logic                    gnt_vld;
    logic [W_CHAN-1:0]       gnt_idx;
    logic signed [W_DIN-1:0] gnt_data;

    // Config decode, one-hot capture and eligibility; out-of-range channels
    // match no slot, so they drop out naturally.
    always_comb begin
        en_wr    = bus.wr_en && (bus.wr_addr == W_WR_ADDR'(pid_sched_en_addr));
        en_new   = en_wr ? bus.wr_data[N_CHAN-1:0] : en_mask;
        cap_vec  = '0;
        eligible = '0;
        for (int i = 0; i < N_CHAN; i++) begin
            cap_vec[i]  = bus.adc_dv_in && (bus.adc_chan_in == W_CHAN'(i)) && en_mask[i];
            eligible[i] = pending[i] && en_mask[i] && (lock_cnt[i] == '0);
        end
    end

    rr_arbiter #(
        .N_CHAN (N_CHAN),
        .W_CHAN (W_CHAN)
    ) u_arb (
        .req      (eligible),
        .last_gnt (rr_ptr),
        .gnt_vld  (gnt_vld),
        .gnt_idx  (gnt_idx)
    );

    // Expand the winner into a one-hot grant and select its held sample.
    always_comb begin
        gnt_vec  = '0;
        gnt_data = '0;
        for (int i = 0; i < N_CHAN; i++) begin
            if (gnt_vld && (gnt_idx == W_CHAN'(i))) begin
                gnt_vec[i] = 1'b1;
                gnt_data   = hold[i];
            end
        end
    end

    // Pending bits: capture sets (and survives a same-edge grant), grant
    // clears, disabling a channel clears.
    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (rst_in) begin
            pending <= '0;
        end else begin
            pending <= (cap_vec | (pending & ~gnt_vec)) & en_new;
        end
    end

    // Channel enable mask from the config port.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            en_mask <= '0;
        end else begin
            en_mask <= en_new;
        end
    end

    // Lockout counters: load on grant, otherwise count down to zero.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < N_CHAN; i++) lock_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_CHAN; i++) begin
                if (gnt_vec[i]) begin
                    lock_cnt[i] <= LOCK_LOAD;
                end else if (lock_cnt[i] != '0) begin
                    lock_cnt[i] <= lock_cnt[i] - W_LOCK'(1);
                end
            end
        end
    end

    // Sample hold store; the newest sample always overwrites.
    always_ff @(posedge clk_in) begin
        // NOTE: the hold array is deliberately not reset; a slot is only read
        // once its pending bit is set, which always follows a fresh write.
        for (int i = 0; i < N_CHAN; i++) begin
            if (cap_vec[i]) hold[i] <= bus.adc_data_in;
        end
    end

    // Registered issue and round-robin pointer; chan/data hold when idle.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            dv_q   <= 1'b0;
            chan_q <= '0;
            data_q <= '0;
            rr_ptr <= W_CHAN'(N_CHAN - 1);
        end else begin
            dv_q <= gnt_vld;
            if (gnt_vld) begin
                chan_q <= gnt_idx;
                data_q <= gnt_data;
                rr_ptr <= gnt_idx;
            end
        end
    end

    assign bus.dv_out      = dv_q;
    assign bus.chan_out    = chan_q;
    assign bus.data_out    = data_q;
    assign bus.pending_out = pending;

`ifdef PID_SCHED_OVR_CNT_EN
    logic             ovr_clr;
    logic             ovr_evt;
    logic [W_OVR-1:0] ovr_cnt;

    // An overwrite of a pending sample that is not being issued this edge.
    assign ovr_clr = bus.wr_en && (bus.wr_addr == W_WR_ADDR'(pid_sched_ovr_clr_addr));
    assign ovr_evt = |(cap_vec & pending & ~gnt_vec);

    // Saturating overrun counter; a clear beats a same-edge overrun.
    always_ff @(posedge clk_in) begin
        if (rst_in || ovr_clr) begin
            ovr_cnt <= '0;
        end else if (ovr_evt && (ovr_cnt != '1)) begin
            ovr_cnt <= ovr_cnt + W_OVR'(1);
        end
    end

    assign bus.ovr_count_out = ovr_cnt;
`endif

    // Config channel and upper data bits carry nothing for this block.
    logic unused_cfg;
    assign unused_cfg = ^{bus.wr_chan, bus.wr_data[W_WR_DATA-1:N_CHAN]};

endmodule

// File: tb/tb_pid_chan_sched.sv
// tb_pid_chan_sched: directed scenarios plus randomized traffic checked by a
// scoreboard against a behavioural model of the scheduling rules.
module tb_pid_chan_sched;
    import pid_chan_sched_pkg::*;

    localparam int N     = N_CHAN_DEF;
    localparam int LOCK  = LOCKOUT_CYCLES_DEF;
    localparam int WD    = W_DIN_DEF;
    localparam int OVMAX = (1 << W_OVR_DEF) - 1;

    logic clk_in = 1'b0;
    logic rst_in;
    always #5 clk_in = ~clk_in;

    pid_chan_sched_if bus ();

    pid_chan_sched dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: channel is eligible when it has a sample, is
    // enabled and at least LOCK edges have passed since its last grant.
    typedef struct {
        int edge_n;
        int chan;
        int data;
    } iss_t;

    iss_t sb_q[$];
    bit   m_pend [N];
    bit   m_en   [N];
    int   m_hold [N];
    int   m_last [N];
    int   m_ptr;
    int   m_ovr;
    int   m_last_chan;
    int   m_last_data;
    int   edge_cnt = 0;
    bit   mon_en   = 1'b0;

    always @(posedge clk_in) edge_cnt <= edge_cnt + 1;

    function automatic logic [N-1:0] m_pend_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic int rand_data();
        return int'($urandom_range(0, (1 << WD) - 1)) - (1 << (WD - 1));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 1'b0;
            m_en[i]   = 1'b0;
            m_hold[i] = 0;
            m_last[i] = -1000;
        end
        m_ptr       = N - 1;
        m_ovr       = 0;
        m_last_chan = 0;
        m_last_data = 0;
    endtask

    // Drive one cycle of inputs (called at a falling edge), advance the
    // model across the coming rising edge, then wait for the next falling edge.
    task automatic step(input bit rst, input bit dv, input int chan, input int data,
                        input bit wr, input int addr, input longint wdata);
        int  e;
        int  win;
        bit  pre;
        rst_in          = rst;
        bus.adc_dv_in   = dv;
        bus.adc_chan_in = W_CHAN_DEF'(chan);
        bus.adc_data_in = WD'(data);
        bus.wr_en       = wr;
        bus.wr_addr     = W_WR_ADDR_DEF'(addr);
        bus.wr_chan     = W_WR_CHAN_DEF'($urandom);
        bus.wr_data     = W_WR_DATA_DEF'(wdata);
        e = edge_cnt + 1;
        if (rst) begin
            model_reset();
        end else begin
            pre = (chan < N) ? m_pend[chan] : 1'b0;
            win = -1;
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (win < 0 && m_pend[c] && m_en[c] && (e - m_last[c] >= LOCK)) win = c;
            end
            if (win >= 0) begin
                sb_q.push_back('{edge_n: e, chan: win, data: m_hold[win]});
                m_last[win] = e;
                m_ptr       = win;
                m_pend[win] = 1'b0;
                m_last_chan = win;
                m_last_data = m_hold[win];
            end
            if (dv && chan < N) begin
                if (m_en[chan]) begin
                    if (pre && chan != win && m_ovr < OVMAX) m_ovr++;
                    m_hold[chan] = data;
                    m_pend[chan] = 1'b1;
                end
            end
            if (wr && addr == int'(pid_sched_en_addr)) begin
                for (int i = 0; i < N; i++) begin
                    m_en[i] = wdata[i];
                    if (!m_en[i]) m_pend[i] = 1'b0;
                end
            end
            if (wr && addr == int'(pid_sched_ovr_clr_addr)) m_ovr = 0;
        end
        @(negedge clk_in);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
    endtask

    task automatic sample(input int chan, input int data);
        step(1'b0, 1'b1, chan, data, 1'b0, 0, 0);
    endtask

    task automatic cfg(input int addr, input longint wdata);
        step(1'b0, 1'b0, 0, 0, 1'b1, addr, wdata);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 0, 0, 1'b0, 0, 0);
    endtask

    // Monitor: one cycle after each rising edge, pop and compare any issue
    // due on that edge; also compare idle hold values and pending mask.
    always @(posedge clk_in) begin : monitor
        iss_t exp_iss;
        #1;
        if (mon_en) begin
            if (bus.dv_out === 1'b1) begin
                if (sb_q.size() == 0 || sb_q[0].edge_n != edge_cnt) begin
                    check("issue_unexpected_dv", bus.dv_out, 0);
                end else begin
                    exp_iss = sb_q.pop_front();
                    check("issue_chan", bus.chan_out, exp_iss.chan);
                    check("issue_data", $signed(bus.data_out), exp_iss.data);
                end
            end else if (sb_q.size() > 0 && sb_q[0].edge_n <= edge_cnt) begin
                check("issue_missing_dv", bus.dv_out, 1);
                exp_iss = sb_q.pop_front();
            end else begin
                check("idle_chan_hold", bus.chan_out, m_last_chan);
                check("idle_data_hold", $signed(bus.data_out), m_last_data);
            end
            check("pending_mask", bus.pending_out, m_pend_vec());
`ifdef PID_SCHED_OVR_CNT_EN
            check("ovr_count", bus.ovr_count_out, m_ovr);
`endif
        end
    end

    initial begin
        int     r;
        int     sel;
        int     addr;
        longint wd;

        rst_in          = 1'b1;
        bus.adc_dv_in   = 1'b0;
        bus.adc_chan_in = '0;
        bus.adc_data_in = '0;
        bus.wr_en       = 1'b0;
        bus.wr_addr     = '0;
        bus.wr_chan     = '0;
        bus.wr_data     = '0;
        model_reset();
        @(negedge clk_in);
        do_reset();
        do_reset();
        check("reset_dv", bus.dv_out, 0);
        check("reset_chan", bus.chan_out, 0);
        check("reset_data", $signed(bus.data_out), 0);
        check("reset_pending", bus.pending_out, 0);
        mon_en = 1'b1;

        // 1: all channels disabled, sample is dropped.
        sample(2, 77);
        idle();
        check("t1_dv", bus.dv_out, 0);
        check("t1_pending", bus.pending_out, 0);

        // 2: single sample, one-edge latency, single-cycle issue.
        cfg(int'(pid_sched_en_addr), 64'hFF);
        sample(3, -5);
        idle();
        check("t2_dv", bus.dv_out, 1);
        check("t2_chan", bus.chan_out, 3);
        check("t2_data", $signed(bus.data_out), -5);
        idle();
        check("t2_dv_drop", bus.dv_out, 0);

        // 3: ch5 held pending by its lockout while ch0..ch2 arrive.
        sample(5, 50);
        idle();
        sample(5, 51);
        sample(0, 10);
        sample(1, 11);
        sample(2, 12);
        repeat (10) idle();

        // 4: ch0 every edge, issued once per lockout window with latest data.
        for (int i = 0; i < 30; i++) sample(0, 1000 + i);
        repeat (8) idle();

        // 5: two overwrites during lockout, one overrun.
        cfg(int'(pid_sched_ovr_clr_addr), 0);
        sample(4, 40);
        idle();
        sample(4, 41);
        sample(4, 42);
        repeat (8) idle();
`ifdef PID_SCHED_OVR_CNT_EN
        check("t5_ovr", bus.ovr_count_out, 1);
`endif

        // 6: three channels pending under lockout, then reset drops them.
        sample(1, 61);
        sample(3, 63);
        sample(6, 66);
        sample(6, 67);
        sample(3, 68);
        sample(1, 69);
        check("t6_pre_pending", bus.pending_out, 8'h4A);
        do_reset();
        check("t6_pending", bus.pending_out, 0);
        check("t6_dv", bus.dv_out, 0);
        repeat (3) idle();
        check("t6_quiet", bus.dv_out, 0);
        cfg(int'(pid_sched_en_addr), 64'hFF);
        sample(2, 22);
        idle();
        check("t6_first_chan", bus.chan_out, 2);

        // Randomized traffic, config writes and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 999));
            if (r < 2) begin
                do_reset();
            end else begin
                sel  = int'($urandom_range(0, 9));
                addr = (sel < 5) ? int'(pid_sched_en_addr) :
                       (sel < 8) ? int'(pid_sched_ovr_clr_addr) : int'($urandom_range(0, 65535));
                wd   = longint'($urandom | $urandom);
                step(1'b0, ($urandom_range(0, 9) < 6), int'($urandom_range(0, N + 1)),
                     rand_data(), ($urandom_range(0, 19) == 0), addr, wd);
            end
        end

        repeat (10) idle();
        check("sb_drain", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
